// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared definitions for the traffic-light controller:
//   state_t       - controller states, encoding is visible on State_Out
//   RED/YEL/GRN   - one-hot lamp encodings, bit order {R,Y,G}
//   SEL_*         - Time_Param_Sel codes for the reprogram strobe
//   DEFAULT_*     - interval lengths in seconds used at reset
//   nonzero_or    - picks a fallback when a zero interval is requested
package traffic_pkg;

  typedef enum logic [2:0] {
    MG     = 3'd0,
    MG_EXT = 3'd1,
    MY     = 3'd2,
    WALK   = 3'd3,
    SG     = 3'd4,
    SG_EXT = 3'd5,
    SY     = 3'd6
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [1:0] SEL_BASE = 2'd0;
  localparam logic [1:0] SEL_EXT  = 2'd1;
  localparam logic [1:0] SEL_YEL  = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  localparam logic [3:0] DEFAULT_BASE = 4'd6;
  localparam logic [3:0] DEFAULT_EXT  = 4'd3;
  localparam logic [3:0] DEFAULT_YEL  = 4'd2;

  // A zero-length interval would make the state never expire cleanly,
  // so a zero request falls back to the parameter's default.
  function automatic logic [3:0] nonzero_or(input logic [3:0] value,
                                            input logic [3:0] fallback);
    return (value == 4'd0) ? fallback : value;
  endfunction

endpackage

// File: rtl/traffic_light_fsm_interval_timer.sv
// interval_timer
// Seconds timer for one controller state. A prescaler divides the clock
// into one-second ticks and a seconds counter counts ticks up to length.
// Ports:
//   clock    - system clock
//   Reset    - synchronous active-high reset, clears both counters
//   restart  - clears both counters (state entry forced from outside)
//   length   - dwell length in seconds, never zero
//   expired  - 1-cycle pulse in the last clock of the dwell
module interval_timer #(
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       restart,
  input  logic [3:0] length,
  output logic       expired
);

  localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_CYCLES - 1);

  logic [PRE_W-1:0] prescaler;
  logic [3:0]       seconds;

  assign expired = (prescaler == PRE_MAX) && (seconds == length - 4'd1);

  // Expiry coincides with the state change, so clearing on expired makes
  // every new state start counting from zero on its first cycle.
  always_ff @(posedge clock) begin
    if (Reset || restart || expired) begin
      prescaler <= '0;
      seconds   <= '0;
    end else if (prescaler == PRE_MAX) begin
      prescaler <= '0;
      seconds   <= seconds + 4'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm
// Main traffic-light controller (Moore). Sequences main/side lamps and the
// pedestrian walk lamp with programmable BASE/EXT/YEL intervals.
// Ports:
//   clock          - system clock
//   Reset          - synchronous active-high reset (highest priority)
//   Sensor_Sync    - side-street vehicle present, sampled at expiry only
//   WR_Sync        - walk request, a 1-cycle pulse is enough
//   Prog_Sync      - reprogram strobe, also restarts the cycle at MG
//   Time_Param_Sel - 0=BASE, 1=EXT, 2=YEL, 3=none
//   Time_Value     - new interval in seconds (0 means default)
//   Main_Light     - main street {R,Y,G}
//   Side_Light     - side street {R,Y,G}
//   Walk_Lamp      - pedestrian walk lamp
//   Walk_Pending   - walk request latched, not yet served
//   State_Out      - current state encoding
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int         TICK_CYCLES = 50_000_000,
  parameter logic [3:0] DEF_BASE    = DEFAULT_BASE,
  parameter logic [3:0] DEF_EXT     = DEFAULT_EXT,
  parameter logic [3:0] DEF_YEL     = DEFAULT_YEL
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       Sensor_Sync,
  input  logic       WR_Sync,
  input  logic       Prog_Sync,
  input  logic [1:0] Time_Param_Sel,
  input  logic [3:0] Time_Value,
  output logic [2:0] Main_Light,
  output logic [2:0] Side_Light,
  output logic       Walk_Lamp,
  output logic       Walk_Pending,
  output logic [2:0] State_Out
);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] base_q;
  logic [3:0] ext_q;
  logic [3:0] yel_q;
  logic [3:0] dwell;
  logic       walk_q;
  logic       walk_entry;
  logic       timer_expired;

  // Intervals only change together with a forced restart, so the dwell of
  // the current state is stable for the whole time the state is held.
  interval_timer #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_timer (
    .clock  (clock),
    .Reset  (Reset),
    .restart(Prog_Sync),
    .length (dwell),
    .expired(timer_expired)
  );

  always_comb begin
    dwell = base_q;
    case (state_q)
      MG, MG_EXT, SG: dwell = base_q;
      MY, SY:         dwell = yel_q;
      WALK, SG_EXT:   dwell = ext_q;
      default:        dwell = base_q;
    endcase
  end

  // Next state: advance only on expiry; a reprogram strobe overrides
  // everything and parks the controller at MG entry.
  always_comb begin
    state_d = state_q;
    if (timer_expired) begin
      case (state_q)
        MG:      state_d = Sensor_Sync ? MY : MG_EXT;
        MG_EXT:  state_d = MY;
        MY:      state_d = walk_q ? WALK : SG;
        WALK:    state_d = SG;
        SG:      state_d = Sensor_Sync ? SG_EXT : SY;
        SG_EXT:  state_d = SY;
        SY:      state_d = MG;
        default: state_d = MG;
      endcase
    end
    if (Prog_Sync) begin
      state_d = MG;
    end
  end

  assign walk_entry = (state_d == WALK) && (state_q != WALK);

  // State register, walk latch and interval registers. Clearing the walk
  // latch on WALK entry takes precedence over a request in that same cycle.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q <= MG;
      walk_q  <= 1'b0;
      base_q  <= DEF_BASE;
      ext_q   <= DEF_EXT;
      yel_q   <= DEF_YEL;
    end else begin
      state_q <= state_d;
      if (Prog_Sync || walk_entry) begin
        walk_q <= 1'b0;
      end else if (WR_Sync && (state_q != WALK)) begin
        walk_q <= 1'b1;
      end
      if (Prog_Sync) begin
        case (Time_Param_Sel)
          SEL_BASE: base_q <= nonzero_or(Time_Value, DEF_BASE);
          SEL_EXT:  ext_q  <= nonzero_or(Time_Value, DEF_EXT);
          SEL_YEL:  yel_q  <= nonzero_or(Time_Value, DEF_YEL);
          SEL_NONE: ;
          default:  ;
        endcase
      end
    end
  end

  // Lamp decode straight from the state register; unknown encodings show
  // all-red so the two streets can never be green at the same time.
  always_comb begin
    Main_Light = RED;
    Side_Light = RED;
    Walk_Lamp  = 1'b0;
    case (state_q)
      MG, MG_EXT: Main_Light = GRN;
      MY:         Main_Light = YEL;
      WALK:       Walk_Lamp  = 1'b1;
      SG, SG_EXT: Side_Light = GRN;
      SY:         Side_Light = YEL;
      default:    ;
    endcase
  end

  assign Walk_Pending = walk_q;
  assign State_Out    = state_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb_traffic_light_fsm
// Directed bench for traffic_light_fsm with TICK_CYCLES=4 (one second is
// four clocks). State durations are measured in clocks between changes
// of State_Out and compared with hand-computed dwell times.
module tb_traffic_light_fsm;
  import traffic_pkg::*;

  logic       clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Sensor_Sync = 1'b0;
  logic       WR_Sync = 1'b0;
  logic       Prog_Sync = 1'b0;
  logic [1:0] Time_Param_Sel = 2'd0;
  logic [3:0] Time_Value = 4'd0;
  logic [2:0] Main_Light;
  logic [2:0] Side_Light;
  logic       Walk_Lamp;
  logic       Walk_Pending;
  logic [2:0] State_Out;

  int errors = 0;
  int checks = 0;

  traffic_light_fsm #(
    .TICK_CYCLES(4)
  ) dut (
    .clock         (clock),
    .Reset         (Reset),
    .Sensor_Sync   (Sensor_Sync),
    .WR_Sync       (WR_Sync),
    .Prog_Sync     (Prog_Sync),
    .Time_Param_Sel(Time_Param_Sel),
    .Time_Value    (Time_Value),
    .Main_Light    (Main_Light),
    .Side_Light    (Side_Light),
    .Walk_Lamp     (Walk_Lamp),
    .Walk_Pending  (Walk_Pending),
    .State_Out     (State_Out)
  );

  always #5 clock = ~clock;

  // Safety: main and side must never both be non-red in the same cycle.
  always @(negedge clock) begin
    checks++;
    if ((Main_Light != RED) && (Side_Light != RED)) begin
      errors++;
      $display("[TB] FAIL safety: main=%b side=%b both non-red", Main_Light, Side_Light);
    end
  end

  // Counts clocks until State_Out changes; gives up after 200 clocks.
  task automatic wait_change(output int cycles);
    logic [2:0] start;
    bit         done;
    start  = State_Out;
    cycles = 0;
    done   = 1'b0;
    while (!done && cycles < 200) begin
      @(posedge clock);
      #1;
      cycles++;
      if (State_Out !== start) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: state stuck at %0d for %0d cycles, required a change", start, cycles);
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    Reset          = 1'b1;
    Sensor_Sync    = 1'b0;
    WR_Sync        = 1'b0;
    Prog_Sync      = 1'b0;
    Time_Param_Sel = 2'd0;
    Time_Value     = 4'd0;
    repeat (2) @(negedge clock);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    Reset   = 1'b1;
    WR_Sync = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (State_Out !== 3'(MG)) begin
      errors++; $display("[TB] FAIL reset_state: got %0d expected %0d", State_Out, MG);
    end
    checks++;
    if (Main_Light !== 3'b001 || Side_Light !== 3'b100) begin
      errors++; $display("[TB] FAIL reset_lamps: got main=%b side=%b expected 001/100", Main_Light, Side_Light);
    end
    checks++;
    if (Walk_Lamp !== 1'b0 || Walk_Pending !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_walk: got lamp=%b pending=%b expected 0/0", Walk_Lamp, Walk_Pending);
    end
    WR_Sync = 1'b0;
    Reset   = 1'b0;
  endtask

  task automatic test_idle();
    state_t     exp_state [5] = '{MG_EXT, MY, SG, SY, MG};
    int         exp_len   [5] = '{24, 24, 8, 24, 8};
    logic [2:0] exp_main  [5] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b001};
    logic [2:0] exp_side  [5] = '{3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    int c;
    int total;
    total = 0;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      wait_change(c);
      total += c;
      checks++;
      if (c !== exp_len[i]) begin
        errors++; $display("[TB] FAIL idle_len[%0d]: got %0d cycles expected %0d", i, c, exp_len[i]);
      end
      checks++;
      if (State_Out !== 3'(exp_state[i])) begin
        errors++; $display("[TB] FAIL idle_state[%0d]: got %0d expected %0d", i, State_Out, exp_state[i]);
      end
      checks++;
      if (Main_Light !== exp_main[i] || Side_Light !== exp_side[i] || Walk_Lamp !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_lamps[%0d]: got %b/%b/%b expected %b/%b/0", i,
                 Main_Light, Side_Light, Walk_Lamp, exp_main[i], exp_side[i]);
      end
    end
    checks++;
    if (total !== 88) begin
      errors++; $display("[TB] FAIL idle_period: got %0d expected 88", total);
    end
  endtask

  task automatic test_sensor();
    state_t exp_state [5] = '{MY, SG, SG_EXT, SY, MG};
    int     exp_len   [5] = '{24, 8, 24, 12, 8};
    int c;
    int total;
    total = 0;
    apply_reset();
    Sensor_Sync = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_change(c);
      total += c;
      checks++;
      if (c !== exp_len[i] || State_Out !== 3'(exp_state[i])) begin
        errors++;
        $display("[TB] FAIL sensor[%0d]: got %0d cycles to state %0d expected %0d to %0d", i,
                 c, State_Out, exp_len[i], exp_state[i]);
      end
    end
    checks++;
    if (total !== 76) begin
      errors++; $display("[TB] FAIL sensor_period: got %0d expected 76", total);
    end
    Sensor_Sync = 1'b0;
  endtask

  task automatic test_walk();
    state_t exp_state [5] = '{SY, MG, MG_EXT, MY, SG};
    int     exp_len   [5] = '{24, 8, 24, 24, 8};
    int c;
    apply_reset();
    repeat (2) @(negedge clock);
    WR_Sync = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (Walk_Pending !== 1'b1) begin
      errors++; $display("[TB] FAIL walk_latch: got %b expected 1", Walk_Pending);
    end
    @(negedge clock);
    WR_Sync = 1'b0;
    wait_change(c);
    wait_change(c);
    checks++;
    if (c !== 24 || State_Out !== 3'(MY)) begin
      errors++; $display("[TB] FAIL walk_to_my: got %0d cycles state %0d expected 24 state %0d", c, State_Out, MY);
    end
    wait_change(c);
    checks++;
    if (c !== 8 || State_Out !== 3'(WALK)) begin
      errors++; $display("[TB] FAIL walk_entry: got %0d cycles state %0d expected 8 state %0d", c, State_Out, WALK);
    end
    checks++;
    if (Walk_Lamp !== 1'b1 || Walk_Pending !== 1'b0 || Main_Light !== 3'b100 || Side_Light !== 3'b100) begin
      errors++;
      $display("[TB] FAIL walk_outputs: got lamp=%b pending=%b main=%b side=%b expected 1/0/100/100",
               Walk_Lamp, Walk_Pending, Main_Light, Side_Light);
    end
    wait_change(c);
    checks++;
    if (c !== 12 || State_Out !== 3'(SG) || Walk_Lamp !== 1'b0) begin
      errors++;
      $display("[TB] FAIL walk_len: got %0d cycles state %0d lamp %b expected 12 state %0d lamp 0",
               c, State_Out, Walk_Lamp, SG);
    end
    for (int i = 0; i < 5; i++) begin
      wait_change(c);
      checks++;
      if (c !== exp_len[i] || State_Out !== 3'(exp_state[i])) begin
        errors++;
        $display("[TB] FAIL walk_after[%0d]: got %0d cycles to state %0d expected %0d to %0d", i,
                 c, State_Out, exp_len[i], exp_state[i]);
      end
    end
  endtask

  task automatic test_reprogram();
    logic [1:0] sel [3] = '{2'd0, 2'd2, 2'd3};
    logic [3:0] val [3] = '{4'd3, 4'd0, 4'd9};
    state_t     exp_state [3] = '{MG_EXT, MY, SG};
    int         exp_len   [3] = '{12, 12, 8};
    int c;
    apply_reset();
    for (int i = 0; i < 3; i++) wait_change(c);
    checks++;
    if (State_Out !== 3'(SG)) begin
      errors++; $display("[TB] FAIL prog_setup: got %0d expected %0d", State_Out, SG);
    end
    for (int p = 0; p < 3; p++) begin
      @(negedge clock);
      WR_Sync = 1'b1;
      @(negedge clock);
      WR_Sync = 1'b0;
      checks++;
      if (Walk_Pending !== 1'b1) begin
        errors++; $display("[TB] FAIL prog_pending_set[%0d]: got %b expected 1", p, Walk_Pending);
      end
      Prog_Sync      = 1'b1;
      Time_Param_Sel = sel[p];
      Time_Value     = val[p];
      @(posedge clock);
      #1;
      checks++;
      if (State_Out !== 3'(MG) || Walk_Pending !== 1'b0) begin
        errors++;
        $display("[TB] FAIL prog_restart[%0d]: got state %0d pending %b expected %0d/0", p, State_Out, Walk_Pending, MG);
      end
      @(negedge clock);
      Prog_Sync = 1'b0;
      for (int i = 0; i < 3; i++) begin
        wait_change(c);
        checks++;
        if (c !== exp_len[i] || State_Out !== 3'(exp_state[i])) begin
          errors++;
          $display("[TB] FAIL prog[%0d][%0d]: got %0d cycles to state %0d expected %0d to %0d", p, i,
                   c, State_Out, exp_len[i], exp_state[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_walk();
    state_t exp_state [3] = '{MG_EXT, MY, SG};
    int     exp_len   [3] = '{24, 24, 8};
    int c;
    int hops;
    @(negedge clock);
    WR_Sync = 1'b1;
    @(negedge clock);
    WR_Sync = 1'b0;
    hops = 0;
    while (State_Out !== 3'(WALK) && hops < 8) begin
      wait_change(c);
      hops++;
    end
    checks++;
    if (State_Out !== 3'(WALK)) begin
      errors++; $display("[TB] FAIL rst_walk_reach: got %0d expected %0d", State_Out, WALK);
    end
    @(negedge clock);
    WR_Sync = 1'b1;
    @(negedge clock);
    checks++;
    if (Walk_Pending !== 1'b0 || Walk_Lamp !== 1'b1) begin
      errors++; $display("[TB] FAIL rst_walk_ignore: got pending=%b lamp=%b expected 0/1", Walk_Pending, Walk_Lamp);
    end
    Reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (State_Out !== 3'(MG) || Walk_Lamp !== 1'b0 || Walk_Pending !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_walk: got state %0d lamp %b pending %b expected %0d/0/0",
               State_Out, Walk_Lamp, Walk_Pending, MG);
    end
    @(negedge clock);
    Reset   = 1'b0;
    WR_Sync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_change(c);
      checks++;
      if (c !== exp_len[i] || State_Out !== 3'(exp_state[i])) begin
        errors++;
        $display("[TB] FAIL rst_defaults[%0d]: got %0d cycles to state %0d expected %0d to %0d", i,
                 c, State_Out, exp_len[i], exp_state[i]);
      end
    end
  endtask

  initial begin
    $display("[TB] traffic_light_fsm directed bench start");
    test_reset();
    test_idle();
    test_sensor();
    test_walk();
    test_reprogram();
    test_reset_mid_walk();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
